// File: rtl/ex_pkg.sv
// Shared definitions for the EX stage: bus widths, stall encodings,
// SPECIAL-opcode function codes, the decoded ID->EX bus layout and
// small arithmetic helpers used by the ALU and the divider.
package ex_pkg;

    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;
    localparam int EX_TO_RF_WD  = 38;
    localparam int StallBus     = 6;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [5:0] FUNC_MFHI = 6'h10;
    localparam logic [5:0] FUNC_MTHI = 6'h11;
    localparam logic [5:0] FUNC_MFLO = 6'h12;
    localparam logic [5:0] FUNC_MTLO = 6'h13;
    localparam logic [5:0] FUNC_DIV  = 6'h1A;
    localparam logic [5:0] FUNC_DIVU = 6'h1B;

    // Field layout of the ID->EX bus, MSB first.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_alu_src1;
        logic [3:0]  sel_alu_src2;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_to_ex_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    // Magnitude of a value when treated as signed; raw value otherwise.
    function automatic logic [31:0] abs32(input logic [31:0] value, input logic is_signed);
        return (is_signed && value[31]) ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative 32-cycle restoring divider used by the EX stage when EX_DIV_EN
// is defined. Works on operand magnitudes and fixes up signs in DONE;
// a zero divisor yields quotient all-ones and remainder = dividend.
module div
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_flag,
    input  logic        start,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic        busy,
    output logic        ready,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  count;
    logic [63:0] acc;
    logic [31:0] divisor;
    logic [31:0] dividend_raw;
    logic        neg_q;
    logic        neg_r;
    logic        by_zero;
    logic [32:0] partial;
    logic [32:0] diff;
    logic [63:0] acc_step;

    // One shift-subtract step: remainder in acc[63:32], quotient in acc[31:0].
    always_comb begin
        partial  = acc[63:31];
        diff     = partial - {1'b0, divisor};
        acc_step = acc;
        if (!diff[32]) begin
            acc_step = {diff[31:0], acc[30:0], 1'b1};
        end else begin
            acc_step = {partial[31:0], acc[30:0], 1'b0};
        end
    end

    // Sequencer: IDLE -> RUN (32 steps) -> DONE -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= 5'd0;
            acc          <= 64'd0;
            divisor      <= 32'd0;
            dividend_raw <= 32'd0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            by_zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc          <= {32'd0, abs32(op1, signed_flag)};
                        divisor      <= abs32(op2, signed_flag);
                        dividend_raw <= op1;
                        neg_q        <= signed_flag & (op1[31] ^ op2[31]);
                        neg_r        <= signed_flag & op1[31];
                        by_zero      <= (op2 == 32'd0);
                        count        <= 5'd0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_step;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sign fix-up and divide-by-zero results, valid while ready is high.
    always_comb begin
        quotient  = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
        remainder = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
        if (by_zero) begin
            quotient  = 32'hFFFF_FFFF;
            remainder = dividend_raw;
        end
    end

    assign busy  = (state != IDLE);
    assign ready = (state == DONE);

endmodule

// File: rtl/ex.sv
// EX stage of the five-stage MIPS pipeline: latches the ID->EX bus, runs the
// ALU, forms data-SRAM requests, owns HI/LO and drives EX->MEM and the EX->ID
// forwarding bus. Define EX_DIV_EN to compile in the iterative divider;
// without it div/divu finish in one cycle and clear HI/LO.
module ex #(
    parameter int ID_TO_EX_WD  = ex_pkg::ID_TO_EX_WD,
    parameter int EX_TO_MEM_WD = ex_pkg::EX_TO_MEM_WD,
    parameter int EX_TO_RF_WD  = ex_pkg::EX_TO_RF_WD
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ex_pkg::StallBus-1:0]  stall,
    input  logic [ID_TO_EX_WD-1:0]       id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0]      ex_to_mem_bus,
    output logic [EX_TO_RF_WD-1:0]       ex_to_rf_bus,
    output logic                         data_sram_en,
    output logic [3:0]                   data_sram_wen,
    output logic [31:0]                  data_sram_addr,
    output logic [31:0]                  data_sram_wdata,
    output logic                         stallreq_for_ex
);
    import ex_pkg::*;

    logic [ID_TO_EX_WD-1:0] bus_reg;
    id_to_ex_t              f;
    logic [5:0]             opcode;
    logic [5:0]             func;
    logic                   is_special;
    logic                   is_mfhi;
    logic                   is_mflo;
    logic                   is_mthi;
    logic                   is_mtlo;
    logic                   is_div;
    logic [31:0]            src1;
    logic [31:0]            src2;
    logic [31:0]            alu_res;
    logic [31:0]            ex_result;
    logic [31:0]            hi;
    logic [31:0]            lo;
    logic                   unused_bits;

    // Pipeline register: bubble when ID stalls but EX moves, hold when EX stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_reg <= '0;
        end else if (stall[2] == Stop && stall[3] == NoStop) begin
            bus_reg <= '0;
        end else if (stall[3] == NoStop) begin
            bus_reg <= id_to_ex_bus;
        end
    end

    assign f          = bus_reg;
    assign opcode     = f.inst[31:26];
    assign func       = f.inst[5:0];
    assign is_special = (opcode == 6'd0);
    assign is_mfhi    = is_special && (func == FUNC_MFHI);
    assign is_mflo    = is_special && (func == FUNC_MFLO);
    assign is_mthi    = is_special && (func == FUNC_MTHI);
    assign is_mtlo    = is_special && (func == FUNC_MTLO);
    assign is_div     = is_special && (func == FUNC_DIV || func == FUNC_DIVU);

    assign unused_bits = ^{stall[1:0], stall[StallBus-1:4], f.inst[25:16]};

    // Operand selection from the one-hot source selects.
    always_comb begin
        src1 = 32'd0;
        if (f.sel_alu_src1[0]) begin
            src1 = f.rdata1;
        end else if (f.sel_alu_src1[1]) begin
            src1 = f.pc;
        end else if (f.sel_alu_src1[2]) begin
            src1 = {27'd0, f.inst[10:6]};
        end

        src2 = 32'd0;
        if (f.sel_alu_src2[0]) begin
            src2 = f.rdata2;
        end else if (f.sel_alu_src2[1]) begin
            src2 = sext16(f.inst[15:0]);
        end else if (f.sel_alu_src2[2]) begin
            src2 = 32'd8;
        end else if (f.sel_alu_src2[3]) begin
            src2 = {16'd0, f.inst[15:0]};
        end
    end

    // ALU, one-hot op order {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}.
    always_comb begin
        alu_res = 32'd0;
        if (f.alu_op[11]) begin
            alu_res = src1 + src2;
        end else if (f.alu_op[10]) begin
            alu_res = src1 - src2;
        end else if (f.alu_op[9]) begin
            alu_res = {31'd0, $signed(src1) < $signed(src2)};
        end else if (f.alu_op[8]) begin
            alu_res = {31'd0, src1 < src2};
        end else if (f.alu_op[7]) begin
            alu_res = src1 & src2;
        end else if (f.alu_op[6]) begin
            alu_res = ~(src1 | src2);
        end else if (f.alu_op[5]) begin
            alu_res = src1 | src2;
        end else if (f.alu_op[4]) begin
            alu_res = src1 ^ src2;
        end else if (f.alu_op[3]) begin
            alu_res = src2 << src1[4:0];
        end else if (f.alu_op[2]) begin
            alu_res = src2 >> src1[4:0];
        end else if (f.alu_op[1]) begin
            alu_res = $unsigned($signed(src2) >>> src1[4:0]);
        end else if (f.alu_op[0]) begin
            alu_res = {src2[15:0], 16'd0};
        end
    end

    assign ex_result = is_mfhi ? hi : (is_mflo ? lo : alu_res);

`ifdef EX_DIV_EN
    logic        div_ready;
    logic        unused_div_busy;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    div u_div (
        .clk         (clk),
        .rst         (rst),
        .signed_flag (func == FUNC_DIV),
        .start       (is_div),
        .op1         (f.rdata1),
        .op2         (f.rdata2),
        .busy        (unused_div_busy),
        .ready       (div_ready),
        .quotient    (div_quo),
        .remainder   (div_rem)
    );

    assign stallreq_for_ex = is_div & ~div_ready;
`else
    assign stallreq_for_ex = 1'b0;
`endif

    // HI/LO: divider results on completion, otherwise mthi/mtlo when EX advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end
`ifdef EX_DIV_EN
        else if (div_ready) begin
            hi <= div_rem;
            lo <= div_quo;
        end
`endif
        else if (stall[3] == NoStop) begin
            if (is_mthi) begin
                hi <= f.rdata1;
            end
            if (is_mtlo) begin
                lo <= f.rdata1;
            end
`ifndef EX_DIV_EN
            if (is_div) begin
                hi <= 32'd0;
                lo <= 32'd0;
            end
`endif
        end
    end

    assign data_sram_en    = f.data_ram_en & ~stallreq_for_ex;
    assign data_sram_wen   = f.data_ram_wen & {4{~stallreq_for_ex}};
    assign data_sram_addr  = f.rdata1 + sext16(f.inst[15:0]);
    assign data_sram_wdata = f.rdata2;

    assign ex_to_mem_bus = {f.pc, f.data_ram_en, f.data_ram_wen, f.sel_rf_res,
                            f.rf_we, f.rf_waddr, ex_result};
    assign ex_to_rf_bus  = {f.rf_we, f.rf_waddr, ex_result};

endmodule

// File: tb/tb_ex.sv
// Directed testbench for the EX stage. Expected values are hand-computed;
// divider expectations depend on whether EX_DIV_EN is defined.
module tb_ex;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall_manual;
    logic [5:0]   stall;
    logic [158:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_rf_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         stallreq_for_ex;

    int           total;
    int           bad;
    logic [31:0]  cnt;

`ifdef EX_DIV_EN
    localparam logic [31:0] EXP_DIV_CYC  = 32'd33;
    localparam logic        EXP_DIV_BUSY = 1'b1;
    localparam logic [31:0] EXP_LO_S     = 32'hFFFF_FFFD;
    localparam logic [31:0] EXP_HI_S     = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_LO_Z     = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_HI_Z     = 32'h0000_0007;
`else
    localparam logic [31:0] EXP_DIV_CYC  = 32'd0;
    localparam logic        EXP_DIV_BUSY = 1'b0;
    localparam logic [31:0] EXP_LO_S     = 32'h0;
    localparam logic [31:0] EXP_HI_S     = 32'h0;
    localparam logic [31:0] EXP_LO_Z     = 32'h0;
    localparam logic [31:0] EXP_HI_Z     = 32'h0;
`endif

    // Simple stall controller: freeze IF..EX while the divider asks for it.
    assign stall = stall_manual | (stallreq_for_ex ? 6'b001111 : 6'b000000);

    ex dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_rf_bus    (ex_to_rf_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .stallreq_for_ex (stallreq_for_ex)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic [11:0] alu_op, input logic [2:0] s1,
                                        input logic [3:0] s2, input logic en,
                                        input logic [3:0] wen, input logic we,
                                        input logic [4:0] waddr, input logic [31:0] r1,
                                        input logic [31:0] r2);
        return {pc, inst, alu_op, s1, s2, en, wen, we, waddr, 1'b0, r1, r2};
    endfunction

    task automatic checkOutput(input string tag, input logic [75:0] actual,
                               input logic [75:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [158:0] bus);
        @(negedge clk);
        id_to_ex_bus = bus;
        @(posedge clk);
        #1;
    endtask

    task automatic waitDivide();
        cnt = 32'd0;
        while (stallreq_for_ex && cnt < 32'd50) begin
            cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    logic [158:0] b_addu, b_sll, b_lui, b_sw, b_mfhi, b_mflo;

    initial begin
        total = 0;
        bad   = 0;
        b_addu = mk(32'hBFC0_0000, 32'h0022_1821, 12'h800, 3'b001, 4'b0001, 1'b0, 4'h0,
                    1'b1, 5'd3, 32'd5, 32'hFFFF_FFFF);
        b_sll  = mk(32'hBFC0_0004, 32'h0002_2100, 12'h008, 3'b100, 4'b0001, 1'b0, 4'h0,
                    1'b1, 5'd4, 32'd0, 32'h0000_000F);
        b_lui  = mk(32'hBFC0_0008, 32'h3C05_1234, 12'h001, 3'b000, 4'b1000, 1'b0, 4'h0,
                    1'b1, 5'd5, 32'd0, 32'd0);
        b_sw   = mk(32'hBFC0_0010, 32'hAC22_FFFC, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF,
                    1'b0, 5'd0, 32'h0000_1000, 32'hDEAD_BEEF);
        b_mfhi = mk(32'hBFC0_0020, 32'h0000_1810, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                    1'b1, 5'd3, 32'd0, 32'd0);
        b_mflo = mk(32'hBFC0_0024, 32'h0000_1812, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                    1'b1, 5'd3, 32'd0, 32'd0);

        rst          = 1'b1;
        stall_manual = 6'd0;
        id_to_ex_bus = b_addu;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset mem bus", ex_to_mem_bus, 76'd0);
        checkOutput("reset rf bus", 76'(ex_to_rf_bus), 76'd0);
        checkOutput("reset sram", 76'({data_sram_en, data_sram_wen, data_sram_addr,
                                       data_sram_wdata}), 76'd0);
        checkOutput("reset stallreq", 76'(stallreq_for_ex), 76'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(b_mfhi);
        checkOutput("reset hi", 76'(ex_to_rf_bus[31:0]), 76'd0);

        applyStimulus(b_addu);
        checkOutput("addu rf bus", 76'(ex_to_rf_bus), 76'({1'b1, 5'd3, 32'd4}));
        checkOutput("addu mem bus", ex_to_mem_bus,
                    {32'hBFC0_0000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'd4});

        applyStimulus(b_sll);
        checkOutput("sll", 76'(ex_to_rf_bus[31:0]), 76'(32'h0000_00F0));
        applyStimulus(b_lui);
        checkOutput("lui", 76'(ex_to_rf_bus[31:0]), 76'(32'h1234_0000));

        applyStimulus(mk(32'h0, 32'h0022_1823, 12'h400, 3'b001, 4'b0001, 1'b0, 4'h0,
                         1'b1, 5'd3, 32'd3, 32'd5));
        checkOutput("sub", 76'(ex_to_rf_bus[31:0]), 76'(32'hFFFF_FFFE));
        applyStimulus(mk(32'h0, 32'h0022_182A, 12'h200, 3'b001, 4'b0001, 1'b0, 4'h0,
                         1'b1, 5'd3, 32'hFFFF_FFFF, 32'd1));
        checkOutput("slt", 76'(ex_to_rf_bus[31:0]), 76'(32'd1));
        applyStimulus(mk(32'h0, 32'h0022_182B, 12'h100, 3'b001, 4'b0001, 1'b0, 4'h0,
                         1'b1, 5'd3, 32'hFFFF_FFFF, 32'd1));
        checkOutput("sltu", 76'(ex_to_rf_bus[31:0]), 76'(32'd0));
        applyStimulus(mk(32'h0, 32'h0022_1807, 12'h002, 3'b001, 4'b0001, 1'b0, 4'h0,
                         1'b1, 5'd3, 32'd4, 32'h8000_0000));
        checkOutput("sra", 76'(ex_to_rf_bus[31:0]), 76'(32'hF800_0000));
        applyStimulus(mk(32'h0, 32'h0022_1827, 12'h040, 3'b001, 4'b0001, 1'b0, 4'h0,
                         1'b1, 5'd3, 32'h0F0F_0F0F, 32'h00FF_00FF));
        checkOutput("nor", 76'(ex_to_rf_bus[31:0]), 76'(32'hF000_F000));

        applyStimulus(b_sw);
        checkOutput("sw addr", 76'(data_sram_addr), 76'(32'h0000_0FFC));
        checkOutput("sw wdata", 76'(data_sram_wdata), 76'(32'hDEAD_BEEF));
        checkOutput("sw en wen", 76'({data_sram_en, data_sram_wen}), 76'(5'h1F));
        checkOutput("sw mem bus", ex_to_mem_bus,
                    {32'hBFC0_0010, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_0FFC});

        applyStimulus(mk(32'h0, 32'h0020_0011, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                         1'b0, 5'd0, 32'h1111_2222, 32'd0));
        applyStimulus(mk(32'h0, 32'h0020_0013, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                         1'b0, 5'd0, 32'h3333_4444, 32'd0));
        applyStimulus(b_mfhi);
        checkOutput("mthi then mfhi", 76'(ex_to_rf_bus[31:0]), 76'(32'h1111_2222));
        applyStimulus(b_mflo);
        checkOutput("mtlo then mflo", 76'(ex_to_rf_bus[31:0]), 76'(32'h3333_4444));

        // Signed divide -7 / 2.
        applyStimulus(mk(32'hBFC0_0040, 32'h0022_001A, 12'h000, 3'b000, 4'b0000, 1'b0,
                         4'h0, 1'b0, 5'd0, 32'hFFFF_FFF9, 32'd2));
        id_to_ex_bus = b_mflo;
        waitDivide();
        checkOutput("div stall cycles", 76'(cnt), 76'(EXP_DIV_CYC));
        @(posedge clk);
        #1;
        checkOutput("div mflo", 76'(ex_to_rf_bus[31:0]), 76'(EXP_LO_S));
        applyStimulus(b_mfhi);
        checkOutput("div mfhi", 76'(ex_to_rf_bus[31:0]), 76'(EXP_HI_S));

        // Unsigned divide by zero 7 / 0.
        applyStimulus(mk(32'hBFC0_0050, 32'h0022_001B, 12'h000, 3'b000, 4'b0000, 1'b0,
                         4'h0, 1'b0, 5'd0, 32'd7, 32'd0));
        id_to_ex_bus = b_mfhi;
        waitDivide();
        checkOutput("divu0 stall cycles", 76'(cnt), 76'(EXP_DIV_CYC));
        @(posedge clk);
        #1;
        checkOutput("divu0 mfhi", 76'(ex_to_rf_bus[31:0]), 76'(EXP_HI_Z));
        applyStimulus(b_mflo);
        checkOutput("divu0 mflo", 76'(ex_to_rf_bus[31:0]), 76'(EXP_LO_Z));

        // Reset in the middle of a divide.
        applyStimulus(mk(32'hBFC0_0060, 32'h0022_001B, 12'h000, 3'b000, 4'b0000, 1'b0,
                         4'h0, 1'b0, 5'd0, 32'd100, 32'd3));
        id_to_ex_bus = b_mfhi;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("div busy at cycle 10", 76'(stallreq_for_ex), 76'(EXP_DIV_BUSY));
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort stallreq", 76'(stallreq_for_ex), 76'd0);
        checkOutput("abort rf bus", 76'(ex_to_rf_bus), 76'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(b_mfhi);
        checkOutput("abort hi", 76'(ex_to_rf_bus[31:0]), 76'd0);
        applyStimulus(b_mflo);
        checkOutput("abort lo", 76'(ex_to_rf_bus[31:0]), 76'd0);

        // Bubble: ID stopped, EX running.
        applyStimulus(b_addu);
        @(negedge clk);
        stall_manual = 6'b000100;
        id_to_ex_bus = b_lui;
        @(posedge clk);
        #1;
        checkOutput("bubble mem bus", ex_to_mem_bus, 76'd0);
        checkOutput("bubble sram addr", 76'(data_sram_addr), 76'd0);

        // Hold: EX stopped keeps the store in place.
        @(negedge clk);
        stall_manual = 6'd0;
        applyStimulus(b_sw);
        @(negedge clk);
        stall_manual = 6'b001111;
        id_to_ex_bus = b_lui;
        @(posedge clk);
        #1;
        checkOutput("hold sram addr", 76'(data_sram_addr), 76'(32'h0000_0FFC));
        checkOutput("hold rf bus", 76'(ex_to_rf_bus), 76'({1'b0, 5'd0, 32'h0000_0FFC}));
        @(negedge clk);
        stall_manual = 6'd0;
        @(posedge clk);
        #1;
        checkOutput("release lui", 76'(ex_to_rf_bus[31:0]), 76'(32'h1234_0000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex.md
# ex

Execute stage of the five-stage MIPS pipeline, directly downstream of ID. Latches the 159-bit ID→EX bus, runs the ALU, forms data-SRAM requests for loads/stores, owns the HI/LO registers, and runs an iterative divider that stalls the pipeline. Drives the EX→MEM bus and the EX→ID forwarding bus.

## Interface
- `ID_TO_EX_WD`, default 159: input bus width.
- `EX_TO_MEM_WD`, default 76: output bus width.
- `EX_TO_RF_WD`, default 38: forwarding bus width.
- `clk` input, 1 bit: clock.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `stall` input, `StallBus` wide: global stall vector. Bit 2 is ID, bit 3 is EX.
- `id_to_ex_bus` input, 159 bits: {pc, inst, alu_op[11:0], sel_alu_src1[2:0], sel_alu_src2[3:0], data_ram_en, data_ram_wen[3:0], rf_we, rf_waddr[4:0], sel_rf_res, rdata1, rdata2}, MSB first.
- `ex_to_mem_bus` output, 76 bits: {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}.
- `ex_to_rf_bus` output, 38 bits: {rf_we, rf_waddr, ex_result}, used for forwarding.
- `data_sram_en` output, 1 bit: data-SRAM enable.
- `data_sram_wen` output, 4 bits: data-SRAM byte write enables.
- `data_sram_addr` output, 32 bits: data-SRAM address.
- `data_sram_wdata` output, 32 bits: data-SRAM write data.
- `stallreq_for_ex` output, 1 bit: requests a pipeline stall while the divider is busy.

## Operation
**Input register**
- On `rst`: clears to 0.
- Else if `stall[2]` is Stop and `stall[3]` is NoStop: loads 0 (bubble).
- Else if `stall[3]` is NoStop: loads `id_to_ex_bus`.
- Otherwise: holds.

**ALU operand 1** (`sel_alu_src1`, one-hot)
- bit 0: rdata1.
- bit 1: pc.
- bit 2: {27'b0, inst[10:6]}.
- none set: 0.

**ALU operand 2** (`sel_alu_src2`, one-hot)
- bit 0: rdata2.
- bit 1: sign-extended inst[15:0].
- bit 2: 32'd8.
- bit 3: zero-extended inst[15:0].
- none set: 0.

**ALU ops** (`alu_op` order {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}, one-hot)
- add/sub: mod 2^32.
- slt: signed compare. sltu: unsigned compare.
- sll/srl/sra: shift src2 by src1[4:0].
- lui: {src2[15:0], 16'b0}.
- no bit set: result 0.

**Result and memory**
- `ex_result` is HI if inst is mfhi (op 0, func 0x10), LO if mflo (func 0x12), else the ALU result.
- `data_sram_addr` = rdata1 + sign-extended inst[15:0].
- `data_sram_en`/`data_sram_wen` pass through `data_ram_en`/`data_ram_wen`, gated to 0 while `stallreq_for_ex` is high.
- `data_sram_wdata` = rdata2.

**HI/LO**
- mthi (func 0x11) writes rdata1 to HI; mtlo (func 0x13) writes rdata1 to LO.
- Both write at the clock edge while the instruction is in EX and `stall[3]` is NoStop.
- Divider completion writes HI = remainder, LO = quotient.

**Divider FSM** (div func 0x1A signed, divu func 0x1B)
- IDLE → RUN when div/divu is in EX: load |rs| and |rt| (raw values for divu), counter = 0.
- RUN: one restoring shift-subtract step per cycle for 32 cycles. Counter 31 → DONE.
- DONE: apply signs (quotient negated if the operand signs differ; remainder takes the dividend sign) and write HI/LO. Then → IDLE.
- `stallreq_for_ex` = 1 when div/divu is in EX and the FSM is not DONE.
- Divide by zero runs the same latency and yields HI = rs, LO = 32'hFFFF_FFFF.

## Timing
- ALU and SRAM request outputs are combinational from the input register: 0-cycle latency within EX.
- Divider: the instruction enters EX at cycle 0, `stallreq_for_ex` is high for cycles 0–32, and HI/LO are updated at the end of cycle 33. mfhi entering EX at cycle 34 sees the result.
- Reset values: all outputs 0, HI/LO 0, FSM IDLE, counter 0.
- `rst` during RUN aborts to IDLE and leaves HI/LO at 0.
- mthi/mtlo never overlap a divide, because EX is stalled while the divider runs.

## Configuration
- `EX_DIV_EN` defined: the divider FSM is compiled in.
- `EX_DIV_EN` undefined: div/divu complete in one cycle with HI = LO = 0, and `stallreq_for_ex` is tied to 0.

## Structure
- Bus widths `ID_TO_EX_WD`, `EX_TO_MEM_WD`, `EX_TO_RF_WD`, `StallBus`, the `Stop`/`NoStop` encodings, and the func codes 0x10–0x13/0x1A/0x1B go in the shared defines header.
- One sub-module, `div`: inputs clk, rst, signed_flag, start, op1, op2; outputs busy, ready, quotient, remainder. Instantiated only under `EX_DIV_EN`.

## Test plan
- addu with rdata1 = 5, rdata2 = 0xFFFFFFFF, alu_op add, sel src1[0]/src2[0] → `ex_result` = 4, `ex_to_rf_bus` = {1, rd, 4} in the same cycle.
- sll with inst[10:6] = 4, rdata2 = 0x0000_000F → result 0x0000_00F0. lui with imm 0x1234 → 0x1234_0000.
- sw with rdata1 = 0x1000, offset 0xFFFC, wen = 4'hF → addr 0x0FFC, wdata = rdata2, en = 1.
- div with rs = -7, rt = 2 → `stallreq_for_ex` high for 33 cycles; then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; a following mflo returns 0xFFFFFFFD.
- divu with rs = 7, rt = 0 → after 34 cycles HI = 7, LO = 0xFFFFFFFF. Asserting `rst` at cycle 10 of a divide → FSM IDLE, stallreq 0, HI/LO 0 on the next cycle.
- `stall[2]` = Stop with `stall[3]` = NoStop → the next cycle has all outputs 0 (bubble). `stall[3]` = Stop → the input register holds its value.
